// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that lets several requesters share one UART transmitter.
// A granted requester's byte and baud select are latched and handed to the
// transmitter with a one-cycle start pulse. The handshake then waits for the
// transmitter to go active and to report done. A watchdog drops the transfer
// if the transmitter never goes active. After done, the arbiter waits for the
// UART to go quiet before it grants again.

module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACT_TIMEOUT = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [3*NUM_REQ-1:0]   req_baud,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic [2:0]             owner,
  output logic                   tx_start,
  output logic [7:0]             tx_byte,
  output logic [2:0]             tx_baud_sel,
  input  logic                   tx_active,
  input  logic                   tx_done,
  output logic                   timeout_err
);

  localparam int CNT_W = (ACT_TIMEOUT > 1) ? $clog2(ACT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACT,
    WAIT_DONE,
    RECOVER
  } state_t;

  state_t             state;
  logic [2:0]         last_grant;
  logic [CNT_W-1:0]   act_cnt;

  logic [NUM_REQ-1:0] req_rot;
  logic               grant_valid;
  logic [2:0]         grant_idx;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [7:0]         grant_data;
  logic [2:0]         grant_baud;
  logic [NUM_REQ-1:0] owner_onehot;

  // Rotate the request vector so bit 0 is the requester right after the last
  // grant, then take the lowest set bit and map it back to a real index.
  always_comb begin
    req_rot     = NUM_REQ'({req, req} >> (int'(last_grant) + 1));
    grant_valid = 1'b0;
    grant_idx   = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        grant_valid = 1'b1;
        grant_idx   = 3'((int'(last_grant) + 1 + k) % NUM_REQ);
      end
    end
  end

  // Select the winner's byte and baud select and build its ack vector.
  always_comb begin
    grant_onehot = '0;
    grant_data   = 8'd0;
    grant_baud   = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == 3'(i)) begin
        grant_onehot[i] = 1'b1;
        grant_data      = req_data[8*i +: 8];
        grant_baud      = req_baud[3*i +: 3];
      end
    end
  end

  // Decode the current owner into the done vector.
  always_comb begin
    owner_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_onehot[i] = (owner == 3'(i));
    end
  end

  // Transfer FSM. Every output is a register. Pulses default low each cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ack         <= '0;
      done        <= '0;
      busy        <= 1'b0;
      owner       <= 3'd0;
      tx_start    <= 1'b0;
      tx_byte     <= 8'd0;
      tx_baud_sel <= 3'd0;
      timeout_err <= 1'b0;
      act_cnt     <= '0;
      last_grant  <= 3'(NUM_REQ - 1);
    end else begin
      ack         <= '0;
      done        <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state       <= ISSUE;
            busy        <= 1'b1;
            tx_start    <= 1'b1;
            ack         <= grant_onehot;
            owner       <= grant_idx;
            last_grant  <= grant_idx;
            tx_byte     <= grant_data;
            tx_baud_sel <= grant_baud;
          end
        end
        ISSUE: begin
          state   <= WAIT_ACT;
          act_cnt <= '0;
        end
        WAIT_ACT: begin
          if (tx_active) begin
            state <= WAIT_DONE;
          end else if (act_cnt == CNT_LAST) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            act_cnt <= act_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            state <= RECOVER;
            done  <= owner_onehot;
          end
        end
        RECOVER: begin
          if (!tx_done && !tx_active) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Randomised bench for uart_tx_arbiter. A transaction-level reference model
// tracks each transfer by its age and by which UART events it has seen. It
// predicts every output on every cycle. A small UART emulator answers each
// start with a scripted activity/done sequence. Directed sections pin
// hand-computed values. A long random section follows.

module tb_uart_tx_arbiter;

  localparam int NumReq     = 4;
  localparam int ActTimeout = 16;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NumReq-1:0]    req;
  logic [8*NumReq-1:0]  reqData;
  logic [3*NumReq-1:0]  reqBaud;
  logic [NumReq-1:0]    ack;
  logic [NumReq-1:0]    done;
  logic                 busy;
  logic [2:0]           owner;
  logic                 txStart;
  logic [7:0]           txByte;
  logic [2:0]           txBaudSel;
  logic                 txActive;
  logic                 txDone;
  logic                 timeoutErr;

  uart_tx_arbiter #(
    .NUM_REQ    (NumReq),
    .ACT_TIMEOUT(ActTimeout)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_data   (reqData),
    .req_baud   (reqBaud),
    .ack        (ack),
    .done       (done),
    .busy       (busy),
    .owner      (owner),
    .tx_start   (txStart),
    .tx_byte    (txByte),
    .tx_baud_sel(txBaudSel),
    .tx_active  (txActive),
    .tx_done    (txDone),
    .timeout_err(timeoutErr)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: a transfer is either open or not. While open, it is
  // described by its age in cycles and by whether activity and done have
  // been seen. The model keeps the outputs it expects.
  bit               mInFlight;
  bit               mActSeen;
  bit               mDoneSeen;
  int               mAge;
  int               mLast;
  logic [NumReq-1:0] eAck;
  logic [NumReq-1:0] eDone;
  logic             eStart;
  logic             eErr;
  logic             eBusy;
  logic [2:0]       eOwner;
  logic [7:0]       eByte;
  logic [2:0]       eBaud;

  logic [1:0]       uartQ[$];
  int               uartMode;
  bit               strayEn;
  bit               glitch[NumReq];

  // Compare one value against its expectation and count it.
  task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Clear the model to its reset state.
  task automatic modelReset();
    mInFlight = 1'b0;
    mActSeen  = 1'b0;
    mDoneSeen = 1'b0;
    mAge      = 0;
    mLast     = NumReq - 1;
    eAck      = '0;
    eDone     = '0;
    eStart    = 1'b0;
    eErr      = 1'b0;
    eBusy     = 1'b0;
    eOwner    = 3'd0;
    eByte     = 8'd0;
    eBaud     = 3'd0;
  endtask

  // Advance the model by one clock edge, using the inputs sampled at that edge.
  task automatic modelStep();
    int  g;
    bit  found;
    eAck   = '0;
    eDone  = '0;
    eStart = 1'b0;
    eErr   = 1'b0;
    if (!mInFlight) begin
      found = 1'b0;
      g     = 0;
      for (int k = 1; k <= NumReq; k++) begin
        int idx;
        idx = (mLast + k) % NumReq;
        if (!found && req[idx]) begin
          found = 1'b1;
          g     = idx;
        end
      end
      if (found) begin
        mLast     = g;
        eOwner    = 3'(g);
        eByte     = reqData[8*g +: 8];
        eBaud     = reqBaud[3*g +: 3];
        eAck[g]   = 1'b1;
        eStart    = 1'b1;
        mInFlight = 1'b1;
        mAge      = 0;
        mActSeen  = 1'b0;
        mDoneSeen = 1'b0;
      end
    end else if (mAge == 0) begin
      mAge = 1;
    end else if (!mActSeen) begin
      if (txActive) begin
        mActSeen = 1'b1;
      end else if (mAge == ActTimeout) begin
        eErr      = 1'b1;
        mInFlight = 1'b0;
      end else begin
        mAge++;
      end
    end else if (!mDoneSeen) begin
      if (txDone) begin
        mDoneSeen     = 1'b1;
        eDone[eOwner] = 1'b1;
      end
    end else if (!txDone && !txActive) begin
      mInFlight = 1'b0;
    end
    eBusy = mInFlight;
  endtask

  // Compare every DUT output against the model.
  task automatic checkOutput();
    checkField("ack",         32'(ack),        32'(eAck));
    checkField("done",        32'(done),       32'(eDone));
    checkField("busy",        32'(busy),       32'(eBusy));
    checkField("owner",       32'(owner),      32'(eOwner));
    checkField("tx_start",    32'(txStart),    32'(eStart));
    checkField("tx_byte",     32'(txByte),     32'(eByte));
    checkField("tx_baud_sel", 32'(txBaudSel),  32'(eBaud));
    checkField("timeout_err", 32'(timeoutErr), 32'(eErr));
  endtask

  // Script the UART response to a start pulse. The first slot lines up with the
  // cycle the arbiter spends issuing the start.
  task automatic scheduleUart();
    int d;
    int l;
    int tail;
    bit ovl;
    uartQ.delete();
    uartQ.push_back(2'b00);
    if (uartMode == 1) return;
    d    = 1;
    l    = 3;
    ovl  = 1'b0;
    tail = 0;
    if (uartMode == 0) begin
      if ($urandom_range(0, 9) == 0) return;
      case ($urandom_range(0, 5))
        0:       d = ActTimeout - 1;
        1:       d = ActTimeout;
        default: d = $urandom_range(0, 4);
      endcase
      l    = $urandom_range(0, 4);
      ovl  = 1'($urandom_range(0, 1));
      tail = $urandom_range(0, 2);
    end
    repeat (d) uartQ.push_back(2'b00);
    repeat (l) uartQ.push_back(2'b10);
    uartQ.push_back({ovl, 1'b1});
    uartQ.push_back(2'b01);
    repeat (tail) uartQ.push_back(2'b10);
  endtask

  // Drive the UART inputs for the next edge, clock once, step the model, and check.
  task automatic applyStimulus();
    logic [1:0] v;
    if (uartQ.size() > 0) v = uartQ.pop_front();
    else if (strayEn && !mInFlight && $urandom_range(0, 7) == 0) v = 2'($urandom_range(1, 3));
    else v = 2'b00;
    txActive = v[1];
    txDone   = v[0];
    @(posedge clock);
    if (reset) modelStep();
    #1;
    checkOutput();
    if (eStart) scheduleUart();
  endtask

  // Assert reset between edges, check the immediate clear, then hold and release.
  task automatic pulseReset(input int holdCycles);
    reset = 1'b0;
    modelReset();
    uartQ.delete();
    #1;
    checkOutput();
    checkField("resetAck",   32'(ack),        32'd0);
    checkField("resetDone",  32'(done),       32'd0);
    checkField("resetBusy",  32'(busy),       32'd0);
    checkField("resetOwner", 32'(owner),      32'd0);
    checkField("resetByte",  32'(txByte),     32'd0);
    checkField("resetStart", 32'(txStart),    32'd0);
    checkField("resetErr",   32'(timeoutErr), 32'd0);
    repeat (holdCycles) applyStimulus();
    reset = 1'b1;
  endtask

  // Run until the arbiter goes idle, within a bounded number of cycles.
  task automatic drainIdle(input string name);
    for (int c = 0; c < 60 && busy; c++) applyStimulus();
    checkField(name, 32'(busy), 32'd0);
  endtask

  // Raise one requester with a given byte and baud select.
  task automatic setReq(input int i, input logic [7:0] data, input logic [2:0] baud);
    req[i]            = 1'b1;
    reqData[8*i +: 8] = data;
    reqBaud[3*i +: 3] = baud;
  endtask

  // Global time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  // Directed sections followed by the random section.
  initial begin
    int doneCount;
    int got;
    int lastAck;
    int idx;
    bit found;
    int expOrder[5];
    expOrder = '{0, 1, 2, 3, 0};

    reset    = 1'b0;
    req      = '0;
    reqData  = '0;
    reqBaud  = '0;
    txActive = 1'b0;
    txDone   = 1'b0;
    uartMode = 2;
    strayEn  = 1'b0;
    for (int i = 0; i < NumReq; i++) glitch[i] = 1'b0;
    modelReset();
    #1;
    pulseReset(2);

    // A single request from requester 1.
    setReq(1, 8'hA5, 3'b101);
    applyStimulus();
    checkField("s1Start", 32'(txStart),   32'd1);
    checkField("s1Ack",   32'(ack),       32'b0010);
    checkField("s1Byte",  32'(txByte),    32'hA5);
    checkField("s1Baud",  32'(txBaudSel), 32'd5);
    checkField("s1Owner", 32'(owner),     32'd1);
    req[1]    = 1'b0;
    doneCount = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      applyStimulus();
      if (done != '0) begin
        doneCount++;
        checkField("s1Done", 32'(done), 32'b0010);
      end
    end
    checkField("s1DoneCount", 32'(doneCount), 32'd1);
    checkField("s1Idle",      32'(busy),      32'd0);

    // The transmitter never goes active, so the watchdog fires.
    uartMode = 1;
    setReq(2, 8'h5A, 3'd3);
    applyStimulus();
    checkField("toStart", 32'(txStart), 32'd1);
    checkField("toAck",   32'(ack),     32'b0100);
    req[2] = 1'b0;
    applyStimulus();
    for (int c = 0; c < ActTimeout - 1; c++) begin
      applyStimulus();
      checkField("toEarly", 32'(timeoutErr), 32'd0);
    end
    applyStimulus();
    checkField("toErr",  32'(timeoutErr), 32'd1);
    checkField("toBusy", 32'(busy),       32'd0);
    checkField("toDone", 32'(done),       32'd0);
    uartMode = 2;
    setReq(3, 8'hC3, 3'd6);
    applyStimulus();
    checkField("toNextAck",  32'(ack),    32'b1000);
    checkField("toNextByte", 32'(txByte), 32'hC3);
    req[3] = 1'b0;
    drainIdle("toNextIdle");

    // All requesters held after reset: grants go around in order.
    pulseReset(2);
    for (int i = 0; i < NumReq; i++) setReq(i, 8'(8'h10 + i), 3'(i));
    got     = 0;
    lastAck = -1;
    for (int c = 0; c < 200 && got < 5; c++) begin
      applyStimulus();
      if (txStart) checkField("rrStartQuiet", 32'({txActive, txDone}), 32'd0);
      if (done != '0) checkField("rrDoneOwner", 32'(done), 32'(1 << lastAck));
      if (ack != '0) begin
        idx = 0;
        for (int i = 0; i < NumReq; i++) if (ack[i]) idx = i;
        checkField("rrOrder", 32'(idx), 32'(expOrder[got]));
        lastAck = idx;
        got++;
      end
    end
    checkField("rrGrants", 32'(got), 32'd5);
    req = '0;
    drainIdle("rrIdle");

    // Reset while waiting for done, then a fresh grant.
    setReq(1, 8'h77, 3'd1);
    applyStimulus();
    req[1] = 1'b0;
    found  = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      applyStimulus();
      found = mActSeen && !mDoneSeen;
    end
    checkField("rstReachWaitDone", 32'(found), 32'd1);
    pulseReset(2);
    setReq(2, 8'h99, 3'd4);
    applyStimulus();
    checkField("rstNextAck",  32'(ack),    32'b0100);
    checkField("rstNextByte", 32'(txByte), 32'h99);
    req[2] = 1'b0;
    drainIdle("rstNextIdle");

    // A short request pulse while busy is never served.
    setReq(3, 8'h3C, 3'd2);
    applyStimulus();
    req[3] = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c == 2) setReq(0, 8'hEE, 3'd7);
      else req[0] = 1'b0;
      applyStimulus();
      checkField("holdAck0", 32'(ack[0]),   32'd0);
      checkField("holdByte", 32'(txByte),   32'h3C);
      checkField("holdBaud", 32'(txBaudSel), 32'd2);
      if (!busy) break;
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      checkField("holdLateAck", 32'(ack), 32'd0);
    end

    // Random traffic, random UART timing, stray UART pulses and occasional resets.
    uartMode = 0;
    strayEn  = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 599) == 0) pulseReset($urandom_range(1, 3));
      for (int i = 0; i < NumReq; i++) begin
        if (glitch[i]) begin
          req[i]    = 1'b0;
          glitch[i] = 1'b0;
        end else if (req[i] && eAck[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          int r;
          r = $urandom_range(0, 31);
          if (r <= 3) setReq(i, 8'($urandom), 3'($urandom));
          if (r == 3) glitch[i] = 1'b1;
        end
      end
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
